// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU MEM stage and the host port.
// The statistics counters are built only when DMEM_ARB_STATS_EN is defined.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_SHARE,
        ST_EXCL,
        ST_DRAIN
    } ArbState;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CPU,
        SEL_HOST
    } ArbSel;

    localparam int DMEM_STAT_W = 16;

    function automatic logic [DMEM_STAT_W-1:0] sat_inc(input logic [DMEM_STAT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, host and data-memory buses around the arbiter.
// The slave modport is the arbiter's view; the master modport is the view of everything around it.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    import dmem_arbiter_pkg::*;

    logic                   cpu_req;
    logic                   cpu_we;
    logic [ADDR_W-1:0]      cpu_addr;
    logic [DATA_W-1:0]      cpu_wdata;
    logic [DATA_W-1:0]      cpu_rdata;
    logic                   cpu_stall;

    logic                   host_req;
    logic                   host_we;
    logic [ADDR_W-1:0]      host_addr;
    logic [DATA_W-1:0]      host_wdata;
    logic                   host_excl;
    logic                   host_gnt;
    logic                   host_rvalid;
    logic [DATA_W-1:0]      host_rdata;

    logic                   mem_we;
    logic                   mem_re;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;

    logic                   excl_active;
    logic [DMEM_STAT_W-1:0] stat_conflicts;
    logic [DMEM_STAT_W-1:0] stat_forced;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata, host_excl,
        input  mem_rdata,
        output cpu_rdata, cpu_stall,
        output host_gnt, host_rvalid, host_rdata,
        output mem_we, mem_re, mem_addr, mem_wdata,
        output excl_active, stat_conflicts, stat_forced
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata, host_excl,
        output mem_rdata,
        input  cpu_rdata, cpu_stall,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_we, mem_re, mem_addr, mem_wdata,
        input  excl_active, stat_conflicts, stat_forced
    );

endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles the host was blocked; force_grant
// rises once the count reaches LIMIT so the host gets through on that cycle.
module arb_starve_ctr #(
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic force_grant
);

    localparam logic [3:0] LIMIT_CNT = LIMIT[3:0];

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_CNT)) begin
            count <= count + 4'd1;
        end
    end

    assign force_grant = (count == LIMIT_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU normally wins, the host is forced through after STARVE_LIMIT
// blocked cycles, and host_excl hands the memory wholly to the host. Optional stats: DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 3
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    ArbState           state;
    ArbState           next_state;
    ArbSel             sel;
    logic              force_flag;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;
    logic              starve_inc;
    logic              starve_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_SHARE;
        end else begin
            state <= next_state;
        end
    end

    // ST_DRAIN arbitrates exactly like ST_SHARE; it only differs in being a one-cycle stop after ST_EXCL.
    always_comb begin
        sel        = SEL_NONE;
        next_state = state;
        case (state)
            ST_EXCL: begin
                if (bus.host_req) begin
                    sel = SEL_HOST;
                end
                next_state = bus.host_excl ? ST_EXCL : ST_DRAIN;
            end
            default: begin
                if (bus.cpu_req && bus.host_req) begin
                    sel = force_flag ? SEL_HOST : SEL_CPU;
                end else if (bus.cpu_req) begin
                    sel = SEL_CPU;
                end else if (bus.host_req) begin
                    sel = SEL_HOST;
                end
                next_state = bus.host_excl ? ST_EXCL : ST_SHARE;
            end
        endcase
    end

    always_comb begin
        grant_we    = 1'b0;
        grant_addr  = '0;
        grant_wdata = '0;
        case (sel)
            SEL_CPU: begin
                grant_we    = bus.cpu_we;
                grant_addr  = bus.cpu_addr;
                grant_wdata = bus.cpu_wdata;
            end
            SEL_HOST: begin
                grant_we    = bus.host_we;
                grant_addr  = bus.host_addr;
                grant_wdata = bus.host_wdata;
            end
            default: ;
        endcase
    end

    assign bus.mem_we      = grant_we;
    assign bus.mem_re      = (sel != SEL_NONE) && !grant_we;
    assign bus.mem_addr    = grant_addr;
    assign bus.mem_wdata   = grant_wdata;
    assign bus.cpu_rdata   = bus.mem_rdata;
    assign bus.cpu_stall   = bus.cpu_req && (sel != SEL_CPU);
    assign bus.host_gnt    = (sel == SEL_HOST);
    assign bus.excl_active = (state == ST_EXCL);

    // The counter is pinned at zero in ST_EXCL so the host starts fresh when sharing resumes.
    assign starve_inc = bus.host_req && (sel != SEL_HOST) && (state != ST_EXCL);
    assign starve_clr = (sel == SEL_HOST) || !bus.host_req || (state == ST_EXCL);

    arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .reset      (reset),
        .inc        (starve_inc),
        .clr        (starve_clr),
        .force_grant(force_flag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.host_rvalid <= 1'b0;
            bus.host_rdata  <= '0;
        end else begin
            bus.host_rvalid <= (sel == SEL_HOST) && !bus.host_we;
            if ((sel == SEL_HOST) && !bus.host_we) begin
                bus.host_rdata <= bus.mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [DMEM_STAT_W-1:0] conflicts;
    logic [DMEM_STAT_W-1:0] forced;
    logic                   forced_grant;

    assign forced_grant = (state != ST_EXCL) && bus.cpu_req && bus.host_req && force_flag;

    always_ff @(posedge clk) begin
        if (reset) begin
            conflicts <= '0;
            forced    <= '0;
        end else begin
            if ((state == ST_SHARE) && bus.cpu_req && bus.host_req) begin
                conflicts <= sat_inc(conflicts);
            end
            if (forced_grant) begin
                forced <= sat_inc(forced);
            end
        end
    end

    assign bus.stat_conflicts = conflicts;
    assign bus.stat_forced    = forced;
`else
    assign bus.stat_conflicts = '0;
    assign bus.stat_forced    = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked against a
// cycle-level reference model that tracks ownership mode, host blocked-cycle count and memory contents.
module tb_dmem_arbiter;

    localparam int LIMIT = 3;
`ifdef DMEM_ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus();

    dmem_arbiter #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    logic [7:0] refMem [256];
    int         blocked;
    bit         prevHostExcl;
    bit         wasExcl;
    bit         expRvalid;
    logic [7:0] expRdata;
    int         expConflicts;
    int         expForced;
    bit         armed;
    int         checkCount;
    int         passCount;
    bit         exclHold;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                                 input bit hr, input bit hw, input logic [7:0] ha, input logic [7:0] hd,
                                 input bit hx);
        bus.cpu_req    = cr;
        bus.cpu_we     = cw;
        bus.cpu_addr   = ca;
        bus.cpu_wdata  = cd;
        bus.host_req   = hr;
        bus.host_we    = hw;
        bus.host_addr  = ha;
        bus.host_wdata = hd;
        bus.host_excl  = hx;
        #1;
    endtask

    // Exclusive this cycle iff host_excl was high last cycle; drain iff last cycle was exclusive and excl dropped.
    task automatic stepCycle();
        bit         exclNow, drainNow, both, cpuGnt, hostGnt, weG, reG;
        logic [7:0] aG, dG;
        exclNow  = prevHostExcl;
        drainNow = !prevHostExcl && wasExcl;
        both     = bus.cpu_req && bus.host_req;
        if (exclNow) begin
            cpuGnt  = 1'b0;
            hostGnt = bus.host_req;
        end else if (both) begin
            hostGnt = (blocked >= LIMIT);
            cpuGnt  = !hostGnt;
        end else begin
            cpuGnt  = bus.cpu_req;
            hostGnt = bus.host_req;
        end
        weG = 1'b0;
        aG  = 8'h00;
        dG  = 8'h00;
        if (cpuGnt) begin
            weG = bus.cpu_we;  aG = bus.cpu_addr;  dG = bus.cpu_wdata;
        end
        if (hostGnt) begin
            weG = bus.host_we; aG = bus.host_addr; dG = bus.host_wdata;
        end
        reG = (cpuGnt || hostGnt) && !weG;
        #1;
        if (armed) begin
            checkOutput("cpu_stall",   bus.cpu_stall,   bus.cpu_req && !cpuGnt);
            checkOutput("host_gnt",    bus.host_gnt,    hostGnt);
            checkOutput("mem_we",      bus.mem_we,      weG);
            checkOutput("mem_re",      bus.mem_re,      reG);
            checkOutput("mem_addr",    bus.mem_addr,    aG);
            checkOutput("mem_wdata",   bus.mem_wdata,   dG);
            checkOutput("cpu_rdata",   bus.cpu_rdata,   refMem[aG]);
            checkOutput("excl_active", bus.excl_active, exclNow);
            checkOutput("host_rvalid", bus.host_rvalid, expRvalid);
            checkOutput("host_rdata",  bus.host_rdata,  expRdata);
            checkOutput("stat_conflicts", bus.stat_conflicts, STATS_ON ? expConflicts : 0);
            checkOutput("stat_forced",    bus.stat_forced,    STATS_ON ? expForced : 0);
        end
        @(posedge clk);
        if (weG) refMem[aG] = dG;
        if (reset) begin
            blocked      = 0;
            prevHostExcl = 1'b0;
            wasExcl      = 1'b0;
            expRvalid    = 1'b0;
            expRdata     = 8'h00;
            expConflicts = 0;
            expForced    = 0;
            armed        = 1'b1;
        end else begin
            expRvalid = hostGnt && !bus.host_we;
            if (expRvalid) expRdata = refMem[bus.host_addr];
            if (both && !exclNow && !drainNow) expConflicts++;
            if (both && !exclNow && hostGnt) expForced++;
            if (!exclNow && bus.host_req && !hostGnt) blocked = (blocked < LIMIT) ? blocked + 1 : LIMIT;
            else blocked = 0;
            wasExcl      = exclNow;
            prevHostExcl = bus.host_excl;
        end
        #1;
    endtask

    initial begin
        checkCount   = 0;
        passCount    = 0;
        armed        = 1'b0;
        blocked      = 0;
        prevHostExcl = 1'b0;
        wasExcl      = 1'b0;
        expRvalid    = 1'b0;
        expRdata     = 8'h00;
        expConflicts = 0;
        expForced    = 0;
        exclHold     = 1'b0;
        for (int i = 0; i < 256; i++) begin
            refMem[i] = 8'($urandom);
            mem[i]    = refMem[i];
        end

        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        reset = 1'b0;

        $display("[TB] idle after reset");
        applyStimulus(0, 0, 8'h44, 8'h55, 0, 0, 8'h66, 8'h77, 0);
        checkOutput("idle_mem_re",    bus.mem_re, 0);
        checkOutput("idle_mem_addr",  bus.mem_addr, 0);
        checkOutput("idle_host_gnt",  bus.host_gnt, 0);
        checkOutput("rst_host_rvalid", bus.host_rvalid, 0);
        stepCycle();

        $display("[TB] cpu write then read");
        applyStimulus(1, 1, 8'h10, 8'hA5, 0, 0, 0, 0, 0);
        checkOutput("plan_cpu_mem_we", bus.mem_we, 1);
        checkOutput("plan_cpu_stall0", bus.cpu_stall, 0);
        stepCycle();
        applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("plan_cpu_rdata", bus.cpu_rdata, 8'hA5);
        stepCycle();

        $display("[TB] host read");
        applyStimulus(0, 0, 0, 0, 1, 0, 8'h10, 8'h00, 0);
        checkOutput("plan_host_gnt", bus.host_gnt, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("plan_host_rvalid", bus.host_rvalid, 1);
        checkOutput("plan_host_rdata",  bus.host_rdata, 8'hA5);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("plan_rvalid_pulse", bus.host_rvalid, 0);
        stepCycle();

        $display("[TB] starvation");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 8'h01, 8'h00, 1, 0, 8'h10, 8'h00, 0);
            checkOutput("plan_starve_gnt",   bus.host_gnt,  (i % 4) == 3);
            checkOutput("plan_starve_stall", bus.cpu_stall, (i % 4) == 3);
            stepCycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("plan_stat_forced", bus.stat_forced, STATS_ON ? 2 : 0);
        stepCycle();

        $display("[TB] exclusive mode");
        applyStimulus(1, 0, 8'h02, 8'h00, 0, 0, 0, 0, 1);
        checkOutput("plan_excl_req_cycle", bus.cpu_stall, 0);
        stepCycle();
        applyStimulus(1, 0, 8'h02, 8'h00, 1, 1, 8'h20, 8'h3C, 1);
        checkOutput("plan_excl_stall",  bus.cpu_stall, 1);
        checkOutput("plan_excl_active", bus.excl_active, 1);
        checkOutput("plan_excl_gnt",    bus.host_gnt, 1);
        stepCycle();
        applyStimulus(1, 0, 8'h02, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("plan_excl_last", bus.cpu_stall, 1);
        stepCycle();
        applyStimulus(1, 0, 8'h02, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("plan_drain_excl",  bus.excl_active, 0);
        checkOutput("plan_drain_stall", bus.cpu_stall, 0);
        stepCycle();
        applyStimulus(1, 0, 8'h20, 8'h00, 0, 0, 0, 0, 0);
        checkOutput("plan_excl_written", bus.cpu_rdata, 8'h3C);
        stepCycle();

        $display("[TB] reset after host read");
        applyStimulus(0, 0, 0, 0, 1, 0, 8'h20, 8'h00, 0);
        stepCycle();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycle();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("plan_rst_rvalid", bus.host_rvalid, 0);
        checkOutput("plan_rst_share",  bus.excl_active, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("plan_rst_reexcl", bus.excl_active, 1);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) exclHold = !exclHold;
            applyStimulus($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)), 8'($urandom),
                          $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                          8'($urandom_range(0, 15)), 8'($urandom),
                          exclHold);
            stepCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data memory between two requesters: the CPU MEM stage and a host port used to preload and dump memory.
- CPU normally wins. A starvation counter forces a host grant after STARVE_LIMIT blocked cycles.
- An exclusive mode hands the memory wholly to the host, for preload before start and dump after done.
- Sits between the EX/MEM register, the memory page address logic and the data memory. Drives a stall request into the hazard/stall path.

Parameters:
ADDR_W, 8, memory address width (already page-adjusted)
DATA_W, 8, data width
STARVE_LIMIT, 3, consecutive blocked host-request cycles before the host is forced through (1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cpu_req  in  1  MEM stage access this cycle (memRead|memWrite)
cpu_we  in  1  CPU write
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, combinational from mem_rdata
cpu_stall  out  1  CPU access not served this cycle; pipeline must freeze EX/MEM and earlier
host_req  in  1  host access request, held until granted
host_we  in  1  host write
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_excl  in  1  request exclusive host ownership
host_gnt  out  1  host access performed this cycle
host_rvalid  out  1  registered read data valid, one cycle after a granted read
host_rdata  out  DATA_W  registered read data
mem_we  out  1  to data memory write enable
mem_re  out  1  to data memory read enable
mem_addr  out  ADDR_W  muxed address
mem_wdata  out  DATA_W  muxed write data
mem_rdata  in  DATA_W  memory async read data
excl_active  out  1  FSM in ST_EXCL
stat_conflicts  out  16  cycles where both requested (feature-gated)
stat_forced  out  16  forced host grants (feature-gated)

Behaviour:
- Memory model: combinational read, write on posedge clk.
- Reset values: host_rvalid=0, host_rdata=0, excl_active=0, starve count=0, state=ST_SHARE, stats=0. Combinational outputs follow the inputs with state at reset.

FSM states: ST_SHARE, ST_EXCL, ST_DRAIN.

ST_SHARE:
- cpu_req only: CPU granted, cpu_stall=0.
- host_req only: host granted.
- Both requested:
  - CPU wins unless starve_cnt==STARVE_LIMIT.
  - If it is at the limit, the host wins and cpu_stall=1 for that single cycle.
- starve_cnt rules:
  - Increments (saturating at STARVE_LIMIT) on each cycle with host_req && !host_gnt.
  - Clears on host_gnt or !host_req.
- host_excl=1 goes to ST_EXCL next cycle. The current cycle is still arbitrated in ST_SHARE.

ST_EXCL:
- Host always granted when host_req=1.
- cpu_stall=cpu_req.
- starve_cnt held at 0.
- host_excl=0 goes to ST_DRAIN.

ST_DRAIN:
- One cycle, arbitrated as ST_SHARE. Lets a pending host_rvalid retire.
- Always returns to ST_SHARE, or to ST_EXCL if host_excl has re-asserted.

Grant outputs:
- Granted path drives mem_addr and mem_wdata.
- mem_we = granted_we; mem_re = granted && !granted_we.
- Nothing granted: mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0.
- host_gnt is combinational in the cycle of access.
- Granted host read: host_rdata<=mem_rdata and host_rvalid<=1 on that edge; host_rvalid is a single-cycle pulse.

Other rules:
- cpu_stall never asserts when cpu_req=0.
- Back-to-back forced grants are impossible: the counter restarts at 0 after each host grant.
- Reset mid-operation: any pending host_rvalid is dropped. The FSM returns to ST_SHARE regardless of host_excl; ST_EXCL is re-entered one cycle after reset deasserts if host_excl is still high.
- Addresses and data pass through unmodified; width matching is the caller's job.

Optional Feature:
DMEM_ARB_STATS_EN.
- With macro:
  - stat_conflicts increments each ST_SHARE cycle with cpu_req&&host_req.
  - stat_forced increments on each starvation-forced host grant.
  - Both saturate at 16'hFFFF and clear on reset.
- Without macro: both ports tied to 0 and no counter flops are synthesized.
- Port list is identical either way.

Decomposition:
- Shared package Defs:
  - ArbState enum {ST_SHARE, ST_EXCL, ST_DRAIN}.
  - ArbSel enum {SEL_NONE, SEL_CPU, SEL_HOST}.
  - Constant DMEM_STAT_W=16.
- One natural sub-module, arb_starve_ctr: saturating counter with inc, clr, limit compare, producing the force flag.

Test Plan:
- Reset then cpu_req=1, we=1, addr=8'h10, wdata=8'hA5 with host idle -> mem_we=1, cpu_stall=0; next cycle read of 8'h10 returns cpu_rdata=8'hA5.
- host_req read addr 8'h10 with CPU idle -> host_gnt same cycle; next cycle host_rvalid=1, host_rdata=8'hA5 for exactly one cycle.
- cpu_req and host_req held continuously, STARVE_LIMIT=3 -> host blocked 3 cycles, granted on 4th with cpu_stall=1 for that cycle only, then pattern repeats every 4 cycles; with DMEM_ARB_STATS_EN, stat_forced=2 after 8 cycles.
- host_excl=1 while cpu_req=1 -> from next cycle cpu_stall=1 and excl_active=1; host writes 8'h3C to 8'h20 succeed; host_excl=0 -> one ST_DRAIN cycle, then CPU resumes with cpu_stall=0.
- Reset asserted the cycle after a granted host read -> host_rvalid=0 next cycle, state ST_SHARE, starve count 0.
- Neither requesting -> mem_we=mem_re=0, mem_addr=0, cpu_stall=0, host_gnt=0.
